// File: rtl/irq_prio_pkg.sv
// ----------------------------------------------------------------------------
// irq_prio_pkg
// Shared constants for the priority interrupt controller: the word-address
// map of the register file and the NO_IRQ value returned by an IVR read
// when nothing can be claimed.
// ----------------------------------------------------------------------------
package irq_prio_pkg;

   // Word addresses of the register file.
   localparam int unsigned ADDR_MER = 0;  // master enable, bit 0, RW
   localparam int unsigned ADDR_IER = 1;  // per-source enable, RW
   localparam int unsigned ADDR_IPR = 2;  // pending = irq_s & IER, RO
   localparam int unsigned ADDR_ISR = 3;  // in-service, RO
   localparam int unsigned ADDR_IVR = 4;  // vector read with claim side effect
   localparam int unsigned ADDR_EOI = 5;  // end of interrupt, WO
   localparam int unsigned ADDR_PIN = 6;  // raw irq_i, RO

   // All-ones "no interrupt" vector; wide enough for any data bus, users
   // take the low Dw bits.
   localparam int unsigned NO_IRQ_W = 64;
   localparam logic [NO_IRQ_W-1:0] NO_IRQ = '1;

endpackage

// File: rtl/prio_enc_lsb.sv
// ----------------------------------------------------------------------------
// prio_enc_lsb
// Lowest-set-bit encoder. Index 0 is the highest priority.
//   vec   : input vector to scan
//   valid : at least one bit of vec is set
//   idx   : index of the lowest set bit (0 when valid is low)
// ----------------------------------------------------------------------------
module prio_enc_lsb #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Scan downward so the last hit, i.e. the lowest set index, wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            valid = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_prio_ctrl.sv
// ----------------------------------------------------------------------------
// irq_prio_ctrl
// Priority interrupt controller with in-service nesting and a wishbone
// register slave. A pending source interrupts the CPU only when it outranks
// every interrupt currently in service; the CPU claims it by reading IVR and
// retires it by writing its index to EOI.
//   clk, reset          : clock; asynchronous active-high reset
//   sa_*_i / sa_*_o     : wishbone slave (sel, tag and cyc are ignored)
//   irq_i               : level interrupt requests, bit 0 highest priority
//   cpu_irq_o           : registered interrupt request to the CPU
// ----------------------------------------------------------------------------
module irq_prio_ctrl
   import irq_prio_pkg::*;
#(
   parameter int INT_NUM = 8,
   parameter int Aw      = 3,
   parameter int SELw    = 4,
   parameter int TAGw    = 3,
   parameter int Dw      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [Dw-1:0]      sa_dat_i,
   input  logic [SELw-1:0]    sa_sel_i,
   input  logic [Aw-1:0]      sa_addr_i,
   input  logic [TAGw-1:0]    sa_tag_i,
   input  logic               sa_stb_i,
   input  logic               sa_cyc_i,
   input  logic               sa_we_i,
   output logic [Dw-1:0]      sa_dat_o,
   output logic               sa_ack_o,
   output logic               sa_err_o,
   output logic               sa_rty_o,
   input  logic [INT_NUM-1:0] irq_i,
   output logic               cpu_irq_o
);

   localparam int IW = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

   logic               mer;
   logic [INT_NUM-1:0] ier;
   logic [INT_NUM-1:0] isr;
   logic [INT_NUM-1:0] irq_s;
   logic [INT_NUM-1:0] pend;
   logic               pend_valid, isr_valid, eligible;
   logic [IW-1:0]      top_pend, top_isr;
   logic               access, take_read, take_write;
   logic [Dw-1:0]      rd_data;
   logic [INT_NUM-1:0] isr_set, isr_clr;
   logic               unused_bus;

   assign sa_err_o   = 1'b0;
   assign sa_rty_o   = 1'b0;
   assign unused_bus = ^{sa_sel_i, sa_tag_i, sa_cyc_i};

   assign pend = irq_s & ier;

   prio_enc_lsb #(.N(INT_NUM), .IW(IW)) u_enc_pend (
      .vec   (pend),
      .valid (pend_valid),
      .idx   (top_pend)
   );

   prio_enc_lsb #(.N(INT_NUM), .IW(IW)) u_enc_isr (
      .vec   (isr),
      .valid (isr_valid),
      .idx   (top_isr)
   );

   // A new request may preempt only a strictly lower-priority service level.
   assign eligible = mer & pend_valid & (~isr_valid | (top_pend < top_isr));

   // The strobe is acted on only in the cycle before its ack, so a strobe
   // held across the ack cycle still performs a single access.
   assign access     = sa_stb_i & ~sa_ack_o;
   assign take_read  = access & ~sa_we_i;
   assign take_write = access & sa_we_i;

   always_comb begin
      rd_data = '0;
      isr_set = '0;
      case (sa_addr_i)
         Aw'(ADDR_MER): rd_data = Dw'(mer);
         Aw'(ADDR_IER): rd_data = Dw'(ier);
         Aw'(ADDR_IPR): rd_data = Dw'(pend);
         Aw'(ADDR_ISR): rd_data = Dw'(isr);
         Aw'(ADDR_PIN): rd_data = Dw'(irq_i);
         Aw'(ADDR_IVR): begin
            if (eligible) begin
               rd_data = Dw'(top_pend);
               isr_set = INT_NUM'(1) << top_pend;
            end else begin
               rd_data = NO_IRQ[Dw-1:0];
            end
         end
         default: rd_data = '0;
      endcase
   end

   // EOI matches the full data word, so out-of-range values clear nothing.
   always_comb begin
      isr_clr = '0;
      for (int i = 0; i < INT_NUM; i++) begin
         if (sa_dat_i == Dw'(i)) isr_clr[i] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mer       <= 1'b0;
         ier       <= '0;
         isr       <= '0;
         irq_s     <= '0;
         sa_dat_o  <= '0;
         sa_ack_o  <= 1'b0;
         cpu_irq_o <= 1'b0;
      end else begin
         irq_s     <= irq_i;
         cpu_irq_o <= eligible;
         sa_ack_o  <= access;
         if (take_write && sa_addr_i == Aw'(ADDR_MER)) mer <= sa_dat_i[0];
         if (take_write && sa_addr_i == Aw'(ADDR_IER)) ier <= sa_dat_i[INT_NUM-1:0];
         if (take_read) begin
            sa_dat_o <= rd_data;
            isr      <= isr | isr_set;
         end else if (take_write && sa_addr_i == Aw'(ADDR_EOI)) begin
            isr <= isr & ~isr_clr;
         end
      end
   end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_prio_ctrl
// Self-checking bench for irq_prio_ctrl (INT_NUM=8, Dw=32). Expected read
// data is queued when a read is issued and compared when the ack arrives.
// ----------------------------------------------------------------------------
module tb_irq_prio_ctrl;

   localparam int INT_NUM = 8;
   localparam int Aw      = 3;
   localparam int SELw    = 4;
   localparam int TAGw    = 3;
   localparam int Dw      = 32;

   localparam logic [2:0] A_MER = 3'd0, A_IER = 3'd1, A_IPR = 3'd2, A_ISR = 3'd3,
                          A_IVR = 3'd4, A_EOI = 3'd5, A_PIN = 3'd6, A_BAD = 3'd7;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [Dw-1:0]      sa_dat_i = '0;
   logic [SELw-1:0]    sa_sel_i = '1;
   logic [Aw-1:0]      sa_addr_i = '0;
   logic [TAGw-1:0]    sa_tag_i = '0;
   logic               sa_stb_i = 1'b0;
   logic               sa_cyc_i = 1'b0;
   logic               sa_we_i = 1'b0;
   logic [Dw-1:0]      sa_dat_o;
   logic               sa_ack_o;
   logic               sa_err_o;
   logic               sa_rty_o;
   logic [INT_NUM-1:0] irq_i = '0;
   logic               cpu_irq_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];

   irq_prio_ctrl #(
      .INT_NUM(INT_NUM), .Aw(Aw), .SELw(SELw), .TAGw(TAGw), .Dw(Dw)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sa_dat_i  (sa_dat_i),
      .sa_sel_i  (sa_sel_i),
      .sa_addr_i (sa_addr_i),
      .sa_tag_i  (sa_tag_i),
      .sa_stb_i  (sa_stb_i),
      .sa_cyc_i  (sa_cyc_i),
      .sa_we_i   (sa_we_i),
      .sa_dat_o  (sa_dat_o),
      .sa_ack_o  (sa_ack_o),
      .sa_err_o  (sa_err_o),
      .sa_rty_o  (sa_rty_o),
      .irq_i     (irq_i),
      .cpu_irq_o (cpu_irq_o)
   );

   always #5 clk = ~clk;

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
      bit got = 0;
      @(negedge clk);
      sa_addr_i = addr; sa_dat_i = data; sa_we_i = 1'b1;
      sa_stb_i = 1'b1;  sa_cyc_i = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (sa_ack_o === 1'b1) got = 1;
      end
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0; sa_we_i = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL write_ack addr=%0d: no ack within 8 cycles", addr);
      end
   endtask

   task automatic wb_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
      bit          got = 0;
      logic [31:0] e;
      string       n;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk);
      sa_addr_i = addr; sa_we_i = 1'b0;
      sa_stb_i = 1'b1;  sa_cyc_i = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (sa_ack_o === 1'b1) got = 1;
      end
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no ack within 8 cycles", n);
      end else if (sa_dat_o !== e) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, sa_dat_o, e);
      end
   endtask

   task automatic test_reset();
      wait_cycles(2);
      checks++;
      if ({sa_ack_o, cpu_irq_o, sa_err_o, sa_rty_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outs: got %b expected 0000", {sa_ack_o, cpu_irq_o, sa_err_o, sa_rty_o});
      end
      checks++;
      if (sa_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_dat: got 0x%08h expected 0x00000000", sa_dat_o);
      end
      reset = 1'b0;
      wb_read(A_MER, 32'h0, "reset_mer");
      wb_read(A_IER, 32'h0, "reset_ier");
      wb_read(A_ISR, 32'h0, "reset_isr");
   endtask

   task automatic test_claim();
      wb_write(A_MER, 32'h1);
      wb_write(A_IER, 32'h0C);
      @(negedge clk);
      irq_i = 8'h08;
      wait_cycles(1);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL claim_latency1: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wait_cycles(1);
      checks++;
      if (cpu_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL claim_latency2: cpu_irq_o=%b expected 1", cpu_irq_o);
      end
      wb_read(A_IVR, 32'd3, "claim_ivr");
      wait_cycles(1);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL claim_drop: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wb_read(A_ISR, 32'h08, "claim_isr");
      wb_read(A_PIN, 32'h08, "claim_pin");
   endtask

   task automatic test_nesting();
      @(negedge clk);
      irq_i = 8'h0C;
      wait_cycles(2);
      checks++;
      if (cpu_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL nest_raise: cpu_irq_o=%b expected 1", cpu_irq_o);
      end
      wb_read(A_IVR, 32'd2, "nest_ivr");
      wait_cycles(1);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL nest_drop: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wb_read(A_ISR, 32'h0C, "nest_isr");
      wb_write(A_IER, 32'h2C);
      irq_i = 8'h2C;
      wait_cycles(3);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL nest_low_blocked: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wb_read(A_IPR, 32'h2C, "nest_ipr");
   endtask

   task automatic test_eoi();
      irq_i = 8'h28;  // source 2 drops, 3 and 5 stay high
      wb_write(A_EOI, 32'd2);
      wb_read(A_ISR, 32'h08, "eoi2_isr");
      wait_cycles(2);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL eoi2_cpu: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wb_write(A_EOI, 32'd3);
      wait_cycles(1);
      checks++;
      if (cpu_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL eoi3_reraise: cpu_irq_o=%b expected 1", cpu_irq_o);
      end
      wb_read(A_ISR, 32'h00, "eoi3_isr");
      wb_read(A_IVR, 32'd3, "reclaim_ivr");
      wb_write(A_EOI, 32'd9);
      wb_write(A_EOI, 32'd1);
      wb_read(A_ISR, 32'h08, "eoi9_isr");
      wb_write(A_EOI, 32'd3);
      wb_read(A_ISR, 32'h00, "eoi_clean_isr");
   endtask

   task automatic test_mer_off();
      irq_i = 8'h04;
      wb_write(A_MER, 32'h0);
      wait_cycles(3);
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL mer_off_cpu: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
      wb_read(A_IPR, 32'h04, "mer_off_ipr");
      wb_read(A_IVR, 32'hFFFF_FFFF, "mer_off_ivr");
      wb_read(A_ISR, 32'h00, "mer_off_isr");
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      string       n;
      wb_write(A_MER, 32'h1);
      wait_cycles(2);
      checks++;
      if (cpu_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_cpu: cpu_irq_o=%b expected 1", cpu_irq_o);
      end
      exp_q.push_back(32'd2);
      name_q.push_back("b2b_ivr");
      @(negedge clk);
      sa_addr_i = A_IVR; sa_we_i = 1'b0; sa_stb_i = 1'b1; sa_cyc_i = 1'b1;
      wait_cycles(1);
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (sa_ack_o !== 1'b1 || sa_dat_o !== e) begin
         errors++;
         $display("FAIL %s: ack=%b dat=0x%08h expected ack=1 dat=0x%08h", n, sa_ack_o, sa_dat_o, e);
      end
      wait_cycles(1);  // strobe still held
      checks++;
      if (sa_ack_o !== 1'b0 || sa_dat_o !== 32'd2) begin
         errors++;
         $display("FAIL b2b_single: ack=%b dat=0x%08h expected ack=0 dat=0x00000002", sa_ack_o, sa_dat_o);
      end
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
      wb_read(A_ISR, 32'h04, "b2b_isr");
      wb_read(A_BAD, 32'h0, "addr7_read");
      wb_write(A_BAD, 32'hFF);
      wb_write(A_IPR, 32'hFF);
      wb_read(A_IPR, 32'h04, "ro_ipr");
      wb_read(A_MER, 32'h1, "addr7_no_alias");
      wb_write(A_EOI, 32'd2);
      wb_read(A_ISR, 32'h00, "b2b_clean_isr");
   endtask

   task automatic test_reset_mid();
      wait_cycles(2);
      checks++;
      if (cpu_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre_cpu: cpu_irq_o=%b expected 1", cpu_irq_o);
      end
      @(negedge clk);
      sa_addr_i = A_IVR; sa_we_i = 1'b0; sa_stb_i = 1'b1; sa_cyc_i = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({sa_ack_o, cpu_irq_o} !== 2'b00 || sa_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: ack=%b cpu=%b dat=0x%08h expected 0 0 0x00000000", sa_ack_o, cpu_irq_o, sa_dat_o);
      end
      @(negedge clk);
      checks++;
      if (sa_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_hold: ack=%b expected 0", sa_ack_o);
      end
      sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
      reset = 1'b0;
      wb_read(A_ISR, 32'h00, "mid_isr");
      wb_read(A_MER, 32'h00, "mid_mer");
      checks++;
      if (cpu_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_post_cpu: cpu_irq_o=%b expected 0", cpu_irq_o);
      end
   endtask

   initial begin
      test_reset();
      test_claim();
      test_nesting();
      test_eoi();
      test_mer_off();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 SHALL provide parameter INT_NUM, default 8, number of interrupt inputs (1..32).
REQ-002 SHALL provide parameter Aw, default 3, word-address width.
REQ-003 SHALL provide parameters SELw (default 4), TAGw (default 3) and Dw (default 32), giving bus select, tag and data widths.
REQ-004 SHALL have port clk, input, 1, clock; reset, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports sa_dat_i (in, Dw), sa_sel_i (in, SELw), sa_addr_i (in, Aw), sa_tag_i (in, TAGw), sa_stb_i/sa_cyc_i/sa_we_i (in, 1): wishbone slave request.
REQ-006 SHALL have ports sa_dat_o (out, Dw), sa_ack_o/sa_err_o/sa_rty_o (out, 1): wishbone slave response.
REQ-007 SHALL have port irq_i, input, INT_NUM, level interrupt requests (e.g. ext_int_o of edge-capture units).
REQ-008 SHALL have port cpu_irq_o, output, 1, interrupt request to the CPU.

Function
REQ-009 SHALL register irq_i once into irq_s; pend = irq_s & IER.
REQ-010 SHALL treat index 0 as the highest priority; top_pend and top_isr are the lowest set indices of pend and ISR.
REQ-011 SHALL define eligible = MER & (pend!=0) & (ISR==0 | top_pend < top_isr).
REQ-012 SHALL register cpu_irq_o <= eligible, giving 2-cycle latency from irq_i to cpu_irq_o.
REQ-013 SHALL drive sa_ack_o <= sa_stb_i & ~sa_ack_o, tie sa_err_o and sa_rty_o to 0, and ignore sa_sel_i, sa_tag_i and sa_cyc_i.
REQ-014 SHALL apply all register side effects only when sa_stb_i & ~sa_ack_o, so each transaction acts exactly once.
REQ-015 SHALL register read data on that same cycle, zero-extend it to Dw, and hold sa_dat_o until the next read.
REQ-016 SHALL use this map: 0 MER, bit0, RW; 1 IER, RW; 2 IPR = pend, RO; 3 ISR, RO; 4 IVR, RO-claim; 5 EOI, WO; 6 PIN = raw irq_i, RO.
REQ-017 SHALL, on an IVR read, return top_pend and set ISR[top_pend] when eligible; otherwise it returns all-ones (NO_IRQ) and leaves ISR unchanged.
REQ-018 SHALL, on an EOI write of value n < INT_NUM, clear ISR[n]; a value n >= INT_NUM, or an EOI for an idle bit, is ignored.
REQ-019 SHALL treat writes to RO addresses and to addresses 7+ as ignored; such reads return 0.
REQ-020 SHALL NOT clear ISR when a bit is disabled in IER or MER; only EOI clears ISR.
REQ-021 SHALL re-evaluate cpu_irq_o the cycle after a claim or EOI; a still-asserted level source re-raises it after EOI.
REQ-022 SHALL deassert cpu_irq_o the cycle after a claim when no higher-priority source is pending.

Reset
REQ-023 SHALL, on reset, clear MER, IER, ISR, irq_s, sa_dat_o, sa_ack_o and cpu_irq_o to 0 asynchronously.
REQ-024 SHALL abandon any bus transaction in progress when reset is asserted mid-transaction, with no ack and no side effect.

Structure
REQ-025 SHALL place the register address constants and NO_IRQ in a shared irq_prio_pkg header.
REQ-026 SHALL implement top_pend and top_isr with two instances of sub-module prio_enc_lsb (INT_NUM-bit lowest-set-bit encoder with valid and index outputs).

Verification (INT_NUM=8, Dw=32)
REQ-027 SHALL test: MER=1, IER=0x0C, irq_i=0x08 -> cpu_irq_o=1 two cycles later; IVR read=3, ISR=0x08, cpu_irq_o=0 next cycle.
REQ-028 SHALL test: with ISR=0x08, raise irq_i[2] -> cpu_irq_o=1, IVR=2, ISR=0x0C; then raise irq_i[5] with IER=0x2C -> cpu_irq_o stays 0.
REQ-029 SHALL test: EOI 2 -> ISR=0x08; EOI 3 with irq_i[3] still high -> ISR=0, cpu_irq_o=1 again; EOI 9 -> ISR unchanged.
REQ-030 SHALL test: MER=0 with pend=0x04 -> IVR read=0xFFFFFFFF, ISR unchanged, cpu_irq_o=0.
REQ-031 SHALL test: sa_stb_i held 2 cycles on IVR -> one-cycle sa_ack_o and a single ISR bit set; a read of address 7 returns 0.
REQ-032 SHALL test: assert reset during a claim strobe -> sa_ack_o=0, ISR=0 and cpu_irq_o=0 immediately.
